// File: rtl/pb_key_arbiter.sv
// Key-pad front end: synchronises and debounces seven raw keys, grants one key at a
// time by fixed priority (bit6 highest) and issues one valid/ready press event per grant.
module pb_key_arbiter #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] keys_raw,
    input  logic       note_ready,
    output logic [6:0] keys_onehot,
    output logic       note_valid,
    output logic       key_active,
    output logic       conflict,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [6:0]       sync1_q, sync2_q;
    logic [6:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [7];
    logic [CNT_W-1:0] cnt_d [7];

    state_t     state_q, state_d;
    logic [6:0] gnt_q, gnt_d;
    logic [6:0] onehot_q, onehot_d;
    logic       valid_q, valid_d;
    logic       conflict_q, conflict_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic [6:0] gnt_sel;
    logic       multi_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 7; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 7; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A bit flips only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 7; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_sel = '0;
        for (int i = 0; i < 7; i++) begin
            if (deb_q[i]) begin
                gnt_sel    = '0;
                gnt_sel[i] = 1'b1;
            end
        end
        multi_key = ((deb_q & (deb_q - 7'd1)) != 7'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            onehot_q    <= '0;
            valid_q     <= 1'b0;
            conflict_q  <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            onehot_q    <= onehot_d;
            valid_q     <= valid_d;
            conflict_q  <= conflict_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    // Outputs are computed alongside the next state so they change on the transition edge.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        onehot_d    = onehot_q;
        valid_d     = valid_q;
        conflict_d  = 1'b0;
        press_cnt_d = press_cnt_q;
        case (state_q)
            IDLE: begin
                onehot_d = '0;
                valid_d  = 1'b0;
                if (deb_q != 7'd0) begin
                    gnt_d      = gnt_sel;
                    onehot_d   = gnt_sel;
                    valid_d    = 1'b1;
                    conflict_d = multi_key;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (note_ready) begin
                    press_cnt_d = press_cnt_q + 8'd1;
                    valid_d     = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if ((deb_q & gnt_q) == 7'd0) begin
                    onehot_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                onehot_d = '0;
                valid_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign keys_onehot = onehot_q;
    assign note_valid  = valid_q;
    assign conflict    = conflict_q;
    assign press_cnt   = press_cnt_q;
    assign key_active  = (state_q != IDLE);

endmodule
